id_ex_alu_decode: RTL and testbench
===================================

ID_EX_ALU_DECODE -- requirements
Module: id_ex_alu_decode

Interface
REQ-001 SHALL have port i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port i_valid  input  1  decode stage holds a valid instruction.
REQ-004 SHALL have port i_stall  input  1  hazard unit hold request; register keeps its contents.
REQ-005 SHALL have port i_flush  input  1  branch/hazard kill; register loads a bubble.
REQ-006 SHALL have port i_instr  input  32  RV32I instruction word.
REQ-007 SHALL have ports i_rs1_data, i_rs2_data, i_imm  input  32 each  register-file operands and sign-extended immediate.
REQ-008 SHALL have port o_valid  output  1  execute stage holds a valid instruction.
REQ-009 SHALL have port o_ALUControl  output  4  ALU operation code driven to the execute-stage ALU.
REQ-010 SHALL have ports o_A, o_B  output  32 each  ALU operands.
REQ-011 SHALL have ports o_rd  output  5  and o_reg_write  output  1  destination register and write enable.
REQ-012 SHALL have port o_illegal  output  1  registered instruction is not decodable.
REQ-013 SHALL have port o_illegal_cnt  output  8  saturating count of illegal valid instructions accepted.

Function
REQ-014 SHALL use ALU codes AND=0000, OR=0001, ADD=0010, SUB=0110, SLT=0111, NOR=1100; NOR never generated.
REQ-015 SHALL decode opcode 0110011 (R-type): funct3 000 with funct7 0000000 -> ADD, 0100000 -> SUB; 111 -> AND; 110 -> OR; 010 with funct7 0000000 -> SLT; o_B=i_rs2_data; o_reg_write=1.
REQ-016 SHALL decode opcode 0010011 (I-type): funct3 000 -> ADD, 111 -> AND, 110 -> OR, 010 -> SLT; o_B=i_imm; o_reg_write=1.
REQ-017 SHALL decode opcodes 0000011 (load) as ADD, o_B=i_imm, o_reg_write=1, and 0100011 (store) as ADD, o_B=i_imm, o_reg_write=0.
REQ-018 SHALL decode opcode 1100011 funct3 000/001 (BEQ/BNE) as SUB, o_B=i_rs2_data, o_reg_write=0.
REQ-019 SHALL treat every other opcode/funct combination as illegal: o_ALUControl=0000, o_reg_write=0, o_illegal=1.
REQ-020 SHALL always drive o_A=i_rs1_data and o_rd=i_instr[11:7]; o_reg_write SHALL be 0 when i_instr[11:7]=0.
REQ-021 SHALL register all outputs with latency exactly one cycle from i_valid sampled high.
REQ-022 SHALL, when i_valid=0 and no stall, load a bubble: o_valid=0, o_reg_write=0, o_illegal=0, o_ALUControl=0000, o_A=o_B=0, o_rd=0.
REQ-023 SHALL, with i_stall=1 and i_flush=0, hold every output and o_illegal_cnt unchanged.
REQ-024 SHALL give i_flush priority over i_stall and i_valid: load a bubble per REQ-022.
REQ-025 SHALL increment o_illegal_cnt by 1 on each edge that loads a valid illegal instruction (not stalled, not flushed), saturating at 255.

Reset
REQ-026 SHALL, on i_rst_n low, immediately force o_valid=0, o_reg_write=0, o_illegal=0, o_ALUControl=0000, o_A=o_B=0, o_rd=0, o_illegal_cnt=0, independent of i_clk.
REQ-027 SHALL resume normal loading on the first rising edge after i_rst_n deasserts; reset asserted mid-stall or mid-flush SHALL win.

Verification
REQ-028 SUB x3,x1,x2 (0x402081B3), rs1=10, rs2=3, i_valid=1 -> next cycle o_valid=1, o_ALUControl=0110, o_A=10, o_B=3, o_rd=3, o_reg_write=1.
REQ-029 ADDI x5,x0,-1 with i_imm=0xFFFFFFFF held under i_stall=1 for 3 cycles -> outputs frozen at ADD/o_B=0xFFFFFFFF for all 3 cycles.
REQ-030 BEQ loaded, then i_flush=1 together with i_stall=1 and a valid LW -> next cycle o_valid=0, o_reg_write=0, all outputs bubble.
REQ-031 300 consecutive valid instructions 0xFFFFFFFF -> o_illegal=1 each cycle, o_illegal_cnt stops at 255; illegal word under flush does not count.
REQ-032 SW x2,8(x1) -> o_ALUControl=0010, o_B=8, o_reg_write=0; ADD x0,x1,x2 -> o_reg_write=0.
REQ-033 i_rst_n pulsed low between clock edges while o_valid=1, o_illegal_cnt=7 -> all outputs and counter 0 before the next edge.

Source files
------------

// File: rtl/id_ex_alu_decode.sv
// ID/EX pipeline register with RV32I ALU-control decode for the execute stage.
// Decode is combinational from the ID-stage word; all outputs are registered.
module id_ex_alu_decode (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_rs1_data,
    input  logic [31:0] i_rs2_data,
    input  logic [31:0] i_imm,
    output logic        o_valid,
    output logic [3:0]  o_ALUControl,
    output logic [31:0] o_A,
    output logic [31:0] o_B,
    output logic [4:0]  o_rd,
    output logic        o_reg_write,
    output logic        o_illegal,
    output logic [7:0]  o_illegal_cnt
);

    // NOR (1100) is part of the ALU code space but no RV32I op here maps to it.
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd;
    logic       unused_bits;

    assign opcode      = i_instr[6:0];
    assign rd          = i_instr[11:7];
    assign funct3      = i_instr[14:12];
    assign funct7      = i_instr[31:25];
    assign unused_bits = ^i_instr[24:15];

    logic       dec_legal;
    logic       dec_use_imm;
    logic       dec_wr;
    logic [3:0] dec_alu;

    always_comb begin
        dec_legal   = 1'b0;
        dec_use_imm = 1'b0;
        dec_wr      = 1'b0;
        dec_alu     = ALU_AND;
        case (opcode)
            OP_R: begin
                dec_legal = 1'b1;
                dec_wr    = 1'b1;
                case (funct3)
                    3'b000: begin
                        if (funct7 == 7'b0000000)      dec_alu = ALU_ADD;
                        else if (funct7 == 7'b0100000) dec_alu = ALU_SUB;
                        else                           dec_legal = 1'b0;
                    end
                    3'b111: dec_alu = ALU_AND;
                    3'b110: dec_alu = ALU_OR;
                    3'b010: begin
                        if (funct7 == 7'b0000000) dec_alu = ALU_SLT;
                        else                      dec_legal = 1'b0;
                    end
                    default: dec_legal = 1'b0;
                endcase
            end
            OP_I: begin
                dec_legal   = 1'b1;
                dec_wr      = 1'b1;
                dec_use_imm = 1'b1;
                case (funct3)
                    3'b000:  dec_alu = ALU_ADD;
                    3'b111:  dec_alu = ALU_AND;
                    3'b110:  dec_alu = ALU_OR;
                    3'b010:  dec_alu = ALU_SLT;
                    default: dec_legal = 1'b0;
                endcase
            end
            OP_LOAD: begin
                dec_legal   = 1'b1;
                dec_wr      = 1'b1;
                dec_use_imm = 1'b1;
                dec_alu     = ALU_ADD;
            end
            OP_STORE: begin
                dec_legal   = 1'b1;
                dec_use_imm = 1'b1;
                dec_alu     = ALU_ADD;
            end
            OP_BRANCH: begin
                dec_legal = (funct3 == 3'b000) || (funct3 == 3'b001);
                dec_alu   = ALU_SUB;
            end
            default: dec_legal = 1'b0;
        endcase
        // Illegal words must not leak a partially decoded op or write.
        if (!dec_legal) begin
            dec_alu     = ALU_AND;
            dec_wr      = 1'b0;
            dec_use_imm = 1'b0;
        end
        if (rd == 5'd0) dec_wr = 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid       <= 1'b0;
            o_ALUControl  <= ALU_AND;
            o_A           <= '0;
            o_B           <= '0;
            o_rd          <= '0;
            o_reg_write   <= 1'b0;
            o_illegal     <= 1'b0;
            o_illegal_cnt <= '0;
        end else if (i_flush || (!i_stall && !i_valid)) begin
            // Bubble; the illegal counter is not touched.
            o_valid      <= 1'b0;
            o_ALUControl <= ALU_AND;
            o_A          <= '0;
            o_B          <= '0;
            o_rd         <= '0;
            o_reg_write  <= 1'b0;
            o_illegal    <= 1'b0;
        end else if (!i_stall) begin
            o_valid      <= 1'b1;
            o_ALUControl <= dec_alu;
            o_A          <= i_rs1_data;
            o_B          <= !dec_legal ? 32'd0 : (dec_use_imm ? i_imm : i_rs2_data);
            o_rd         <= rd;
            o_reg_write  <= dec_wr;
            o_illegal    <= !dec_legal;
            if (!dec_legal && (o_illegal_cnt != 8'hFF))
                o_illegal_cnt <= o_illegal_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_id_ex_alu_decode.sv
// Randomized self-checking bench for id_ex_alu_decode against a mnemonic-level model.
module tb_id_ex_alu_decode;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_valid = 1'b0, i_stall = 1'b0, i_flush = 1'b0;
    logic [31:0] i_instr = '0, i_rs1_data = '0, i_rs2_data = '0, i_imm = '0;
    logic        o_valid, o_reg_write, o_illegal;
    logic [3:0]  o_ALUControl;
    logic [31:0] o_A, o_B;
    logic [4:0]  o_rd;
    logic [7:0]  o_illegal_cnt;

    int n_cmp = 0;
    int n_err = 0;

    // Expected execute-stage state
    logic        e_valid, e_rw, e_ill;
    logic [3:0]  e_alu;
    logic [31:0] e_a, e_b;
    logic [4:0]  e_rd;
    logic [7:0]  e_cnt;

    id_ex_alu_decode dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_stall(i_stall),
        .i_flush(i_flush), .i_instr(i_instr), .i_rs1_data(i_rs1_data),
        .i_rs2_data(i_rs2_data), .i_imm(i_imm), .o_valid(o_valid),
        .o_ALUControl(o_ALUControl), .o_A(o_A), .o_B(o_B), .o_rd(o_rd),
        .o_reg_write(o_reg_write), .o_illegal(o_illegal), .o_illegal_cnt(o_illegal_cnt)
    );

    always #5 i_clk = ~i_clk;

    function automatic string mnemonic(input logic [31:0] w);
        logic [6:0] op = w[6:0];
        logic [2:0] f3 = w[14:12];
        logic [6:0] f7 = w[31:25];
        if (op == 7'h33) begin
            if (f3 == 0 && f7 == 0) return "add";
            if (f3 == 0 && f7 == 7'h20) return "sub";
            if (f3 == 7) return "and";
            if (f3 == 6) return "or";
            if (f3 == 2 && f7 == 0) return "slt";
        end else if (op == 7'h13) begin
            if (f3 == 0) return "addi";
            if (f3 == 7) return "andi";
            if (f3 == 6) return "ori";
            if (f3 == 2) return "slti";
        end else if (op == 7'h03) return "lw";
        else if (op == 7'h23) return "sw";
        else if (op == 7'h63) begin
            if (f3 == 0) return "beq";
            if (f3 == 1) return "bne";
        end
        return "";
    endfunction

    task automatic bubble();
        e_valid = 0; e_rw = 0; e_ill = 0; e_alu = 0; e_a = 0; e_b = 0; e_rd = 0;
    endtask

    task automatic model_reset();
        bubble();
        e_cnt = 0;
    endtask

    // Next expected state from the inputs present at the coming edge.
    task automatic model_next();
        string m;
        if (!i_rst_n) begin model_reset(); return; end
        if (i_flush || (!i_stall && !i_valid)) begin bubble(); return; end
        if (i_stall) return;
        m       = mnemonic(i_instr);
        e_valid = 1;
        e_a     = i_rs1_data;
        e_rd    = i_instr[11:7];
        e_ill   = (m == "");
        if (m == "add" || m == "addi" || m == "lw" || m == "sw") e_alu = 4'b0010;
        else if (m == "sub" || m == "beq" || m == "bne")        e_alu = 4'b0110;
        else if (m == "or" || m == "ori")                       e_alu = 4'b0001;
        else if (m == "slt" || m == "slti")                     e_alu = 4'b0111;
        else                                                    e_alu = 4'b0000;
        e_b  = (m == "add" || m == "sub" || m == "and" || m == "or" || m == "slt" ||
                m == "beq" || m == "bne") ? i_rs2_data : i_imm;
        e_rw = !(e_ill || m == "sw" || m == "beq" || m == "bne") && (e_rd != 0);
        if (e_ill && e_cnt != 8'hFF) e_cnt = e_cnt + 8'd1;
    endtask

    task automatic step();
        model_next();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic f, input logic [31:0] w,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] im);
        i_valid = v; i_stall = s; i_flush = f; i_instr = w;
        i_rs1_data = a; i_rs2_data = b; i_imm = im;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0] rd = 5'($urandom_range(0, 31));
        logic [4:0] r1 = 5'($urandom), r2 = 5'($urandom);
        logic [2:0] f3 = 3'($urandom);
        logic [6:0] f7;
        case ($urandom_range(0, 5))
            0: begin
                f7 = ($urandom_range(0, 3) == 0) ? 7'($urandom) : ($urandom_range(0, 1) ? 7'h20 : 7'h00);
                return {f7, r2, r1, f3, rd, 7'h33};
            end
            1: return {12'($urandom), r1, f3, rd, 7'h13};
            2: return {12'($urandom), r1, f3, rd, 7'h03};
            3: return {7'($urandom), r2, r1, f3, 5'($urandom), 7'h23};
            4: return {7'($urandom), r2, r1, f3, 5'($urandom), 7'h63};
            default: return $urandom;
        endcase
    endfunction

    task automatic test_reset();
        i_rst_n = 0;
        model_reset();
        #1;
        n_cmp++;
        if ({o_valid, o_ALUControl, o_A, o_B, o_rd, o_reg_write, o_illegal, o_illegal_cnt} !== '0) begin
            n_err++;
            $display("FAIL reset: got v=%b alu=%b a=%h b=%h rd=%0d rw=%b ill=%b cnt=%0d, need all 0",
                     o_valid, o_ALUControl, o_A, o_B, o_rd, o_reg_write, o_illegal, o_illegal_cnt);
        end
        drive(1, 0, 0, 32'h402081B3, 10, 3, 0);
        step();
        n_cmp++;
        if (o_valid !== 1'b0 || o_illegal_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL reset_held_edge: got v=%b cnt=%0d, need 0/0", o_valid, o_illegal_cnt);
        end
        @(negedge i_clk);
        i_rst_n = 1;
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_sub();
        drive(1, 0, 0, 32'h402081B3, 10, 3, 32'h55);
        step();
        n_cmp++;
        if ({o_valid, o_ALUControl, o_A, o_B, o_rd, o_reg_write, o_illegal} !==
            {1'b1, 4'b0110, 32'd10, 32'd3, 5'd3, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL sub: got v=%b alu=%b a=%0d b=%0d rd=%0d rw=%b ill=%b, need 1/0110/10/3/3/1/0",
                     o_valid, o_ALUControl, o_A, o_B, o_rd, o_reg_write, o_illegal);
        end
        drive(0, 0, 0, 32'h402081B3, 10, 3, 0);
        step();
        n_cmp++;
        if ({o_valid, o_ALUControl, o_A, o_B, o_rd, o_reg_write, o_illegal} !== '0) begin
            n_err++;
            $display("FAIL idle_bubble: got v=%b alu=%b a=%h b=%h rd=%0d rw=%b, need bubble",
                     o_valid, o_ALUControl, o_A, o_B, o_rd, o_reg_write);
        end
    endtask

    task automatic test_stall();
        drive(1, 0, 0, 32'hFFF00293, 0, 32'h1234, 32'hFFFFFFFF);
        step();
        for (int c = 0; c < 3; c++) begin
            drive(1'($urandom), 1, 0, $urandom, $urandom, $urandom, $urandom);
            step();
            n_cmp++;
            if (o_ALUControl !== 4'b0010 || o_B !== 32'hFFFFFFFF || o_rd !== 5'd5 ||
                o_valid !== 1'b1 || o_reg_write !== 1'b1 || o_illegal_cnt !== e_cnt) begin
                n_err++;
                $display("FAIL stall_hold c%0d: got alu=%b b=%h rd=%0d v=%b rw=%b cnt=%0d, need 0010/ffffffff/5/1/1/%0d",
                         c, o_ALUControl, o_B, o_rd, o_valid, o_reg_write, o_illegal_cnt, e_cnt);
            end
        end
    endtask

    task automatic test_flush();
        drive(1, 0, 0, 32'h00208063, 7, 7, 0);
        step();
        n_cmp++;
        if (o_ALUControl !== 4'b0110 || o_reg_write !== 1'b0 || o_valid !== 1'b1) begin
            n_err++;
            $display("FAIL beq: got alu=%b rw=%b v=%b, need 0110/0/1", o_ALUControl, o_reg_write, o_valid);
        end
        drive(1, 1, 1, 32'h0000A183, 9, 9, 4);
        step();
        n_cmp++;
        if ({o_valid, o_ALUControl, o_A, o_B, o_rd, o_reg_write, o_illegal} !== '0) begin
            n_err++;
            $display("FAIL flush_over_stall: got v=%b alu=%b a=%h b=%h rd=%0d rw=%b, need bubble",
                     o_valid, o_ALUControl, o_A, o_B, o_rd, o_reg_write);
        end
    endtask

    task automatic test_store_x0();
        drive(1, 0, 0, 32'h0020A423, 100, 200, 8);
        step();
        n_cmp++;
        if (o_ALUControl !== 4'b0010 || o_B !== 32'd8 || o_reg_write !== 1'b0 || o_A !== 32'd100) begin
            n_err++;
            $display("FAIL sw: got alu=%b a=%0d b=%0d rw=%b, need 0010/100/8/0", o_ALUControl, o_A, o_B, o_reg_write);
        end
        drive(1, 0, 0, 32'h00208033, 1, 2, 0);
        step();
        n_cmp++;
        if (o_ALUControl !== 4'b0010 || o_reg_write !== 1'b0 || o_rd !== 5'd0 || o_B !== 32'd2) begin
            n_err++;
            $display("FAIL add_x0: got alu=%b rw=%b rd=%0d b=%0d, need 0010/0/0/2", o_ALUControl, o_reg_write, o_rd, o_B);
        end
    endtask

    task automatic test_saturate();
        @(negedge i_clk); i_rst_n = 0; model_reset(); #1; i_rst_n = 1;
        @(posedge i_clk); #1;
        drive(1, 0, 1, 32'hFFFFFFFF, 1, 1, 1);
        step();
        n_cmp++;
        if (o_illegal_cnt !== 8'd0 || o_illegal !== 1'b0) begin
            n_err++;
            $display("FAIL flush_illegal: got cnt=%0d ill=%b, need 0/0", o_illegal_cnt, o_illegal);
        end
        for (int c = 0; c < 300; c++) begin
            drive(1, 0, 0, 32'hFFFFFFFF, $urandom, $urandom, $urandom);
            step();
            n_cmp++;
            if (o_illegal !== 1'b1 || o_valid !== 1'b1 || o_ALUControl !== 4'b0000 ||
                o_reg_write !== 1'b0 || o_illegal_cnt !== e_cnt) begin
                n_err++;
                $display("FAIL illegal_run c%0d: got ill=%b v=%b alu=%b rw=%b cnt=%0d, need 1/1/0000/0/%0d",
                         c, o_illegal, o_valid, o_ALUControl, o_reg_write, o_illegal_cnt, e_cnt);
            end
        end
        drive(1, 0, 1, 32'hFFFFFFFF, 0, 0, 0);
        step();
        n_cmp++;
        if (o_illegal_cnt !== 8'd255) begin
            n_err++;
            $display("FAIL saturate: got cnt=%0d, need 255", o_illegal_cnt);
        end
    endtask

    task automatic test_async_reset();
        @(negedge i_clk); i_rst_n = 0; model_reset(); #1; i_rst_n = 1;
        @(posedge i_clk); #1;
        for (int c = 0; c < 7; c++) begin
            drive(1, 0, 0, 32'hFFFFFFFF, 0, 0, 0);
            step();
        end
        drive(1, 0, 0, 32'h402081B3, 10, 3, 0);
        step();
        n_cmp++;
        if (o_valid !== 1'b1 || o_illegal_cnt !== 8'd7) begin
            n_err++;
            $display("FAIL pre_async: got v=%b cnt=%0d, need 1/7", o_valid, o_illegal_cnt);
        end
        drive(1, 1, 0, 32'hFFFFFFFF, 0, 0, 0);
        #2 i_rst_n = 0;
        model_reset();
        #1;
        n_cmp++;
        if ({o_valid, o_ALUControl, o_A, o_B, o_rd, o_reg_write, o_illegal, o_illegal_cnt} !== '0) begin
            n_err++;
            $display("FAIL async_reset: got v=%b alu=%b a=%h b=%h rd=%0d rw=%b ill=%b cnt=%0d, need all 0",
                     o_valid, o_ALUControl, o_A, o_B, o_rd, o_reg_write, o_illegal, o_illegal_cnt);
        end
        drive(1, 1, 1, 32'hFFFFFFFF, 5, 5, 5);
        step();
        n_cmp++;
        if (o_valid !== 1'b0 || o_illegal_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL reset_vs_stall_flush: got v=%b cnt=%0d, need 0/0", o_valid, o_illegal_cnt);
        end
        @(negedge i_clk);
        i_rst_n = 1;
        drive(1, 0, 0, 32'h00A0E213, 6, 0, 32'hA);
        step();
        n_cmp++;
        if (o_valid !== 1'b1 || o_ALUControl !== 4'b0001 || o_B !== 32'hA || o_rd !== 5'd4 || o_reg_write !== 1'b1) begin
            n_err++;
            $display("FAIL post_reset_load: got v=%b alu=%b b=%h rd=%0d rw=%b, need 1/0001/a/4/1",
                     o_valid, o_ALUControl, o_B, o_rd, o_reg_write);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            drive($urandom_range(0, 7) != 0, $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0,
                  rand_instr(), $urandom, $urandom, $urandom);
            step();
            n_cmp++;
            if ({o_valid, o_ALUControl, o_A, o_rd, o_reg_write, o_illegal, o_illegal_cnt} !==
                {e_valid, e_alu, e_a, e_rd, e_rw, e_ill, e_cnt} || (!e_ill && o_B !== e_b)) begin
                n_err++;
                $display("FAIL random c%0d: got v=%b alu=%b a=%h b=%h rd=%0d rw=%b ill=%b cnt=%0d, need v=%b alu=%b a=%h b=%h rd=%0d rw=%b ill=%b cnt=%0d",
                         c, o_valid, o_ALUControl, o_A, o_B, o_rd, o_reg_write, o_illegal, o_illegal_cnt,
                         e_valid, e_alu, e_a, e_b, e_rd, e_rw, e_ill, e_cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sub();
        test_stall();
        test_flush();
        test_store_x0();
        test_saturate();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
